fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 16-bit pipelined core.
- Holds the PC and issues word-addressed requests to instruction memory over a single-outstanding req/valid interface.
- Loads the IF/ID pipeline register consumed by decode, which reads the register file and evaluates branch conditions.
- Accepts the decode-stage branch-taken flag and target, redirects the PC, flushes IF/ID, and discards stale in-flight fetches.

Parameters:
- N, 16, instruction and data width.
- AW, 16, PC / instruction-memory address width (word addressed).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- stall  input  1  decode cannot accept; IF/ID must hold.
- branch_taken  input  1  control-hazard flag from decode; redirect this cycle.
- branch_target  input  AW  redirect address, valid when branch_taken=1.
- imem_req  output  1  fetch request strobe, one cycle wide.
- imem_addr  output  AW  fetch address; equals pc while imem_req=1.
- imem_valid  input  1  response strobe; at most one per request.
- imem_rdata  input  N  instruction word, valid with imem_valid.
- ifid_valid  output  1  IF/ID holds a real instruction.
- ifid_instr  output  N  IF/ID instruction; NOP (all zeros) when invalid.
- ifid_pc  output  AW  address of ifid_instr.

Behaviour:
- Reset (async):
  - pc=RESET_PC, state=REQ, ifid_valid=0, ifid_instr=0, ifid_pc=0, hold buffer cleared.
  - imem_req is combinational from state and is therefore 1 in the first cycle after reset release.
- FSM states: REQ, WAIT, HOLD, DROP. imem_req=1 only in REQ. imem_addr=pc at all times.
- REQ: always -> WAIT next cycle. The request is issued this cycle.
- WAIT: waits for imem_valid.
  - imem_valid & !stall: IF/ID <= {1, imem_rdata, pc}; pc <= pc+1; -> REQ.
  - imem_valid & stall: hold buffer <= {imem_rdata, pc}; -> HOLD.
- HOLD: when !stall, IF/ID <= hold buffer; pc <= pc+1; -> REQ.
- DROP: when imem_valid, the response is discarded (IF/ID unchanged by it); -> REQ.
- IF/ID update rules:
  - stall=1 and no redirect: IF/ID holds all fields.
  - stall=0 and no instruction delivered this cycle: ifid_valid <= 0, ifid_instr <= 0 (bubble).
- Redirect (branch_taken=1) has highest priority over stall and imem_valid:
  - pc <= branch_target; ifid_valid <= 0; ifid_instr <= 0; hold buffer invalidated.
  - In REQ (request in flight): -> DROP.
  - In WAIT with imem_valid=0: -> DROP.
  - In WAIT with imem_valid=1: response discarded; -> REQ.
  - In HOLD: -> REQ.
  - In DROP with imem_valid=0: stay in DROP.
  - In DROP with imem_valid=1: -> REQ.
- Wrap-around: pc+1 is modulo 2^AW (0xFFFF -> 0x0000). No exception is raised.
- Throughput: with a 1-cycle memory, one instruction every 2 cycles. Latency is req to IF/ID visible = memory latency + 1 edge.
- Protocol: imem_valid in REQ or HOLD is a protocol violation. It is ignored; the bench asserts that it never occurs.
- Reset mid-fetch: any outstanding response arriving after reset release is not expected. The memory model is reset together with this block.

Decomposition:
- Shared package cpu_pkg holds:
  - fetch state encoding (REQ=2'd0, WAIT=2'd1, HOLD=2'd2, DROP=2'd3);
  - NOP_INSTR=16'h0000;
  - default RESET_PC.
- One sub-module, ifid_reg: holds valid/instr/pc with load, hold (stall) and flush inputs; async active-high reset to NOP. FSM and PC logic stay in fetch_stage.

Test Plan:
- Reset release, 1-cycle memory returning 0x1111 at addr 0 and 0x2222 at addr 1 -> imem_req pulses at addr 0 then addr 1; ifid_instr=0x1111/ifid_pc=0 then 0x2222/1; ifid_valid is a bubble on alternate cycles.
- Response 0xABCD arrives while stall=1 for 3 cycles -> state HOLD; IF/ID keeps its prior value; 0xABCD/pc loads on the first cycle stall=0; the next req goes to pc+1.
- branch_taken=1, target=0x0040, in WAIT, with the old response arriving 2 cycles later -> ifid_valid=0 immediately; the stale word never reaches IF/ID; the next imem_req has addr 0x0040.
- branch_taken=1 in the same cycle as imem_valid and stall=1 -> redirect wins; no HOLD; next req at target; ifid_valid=0.
- pc=0xFFFF fetch accepted -> next imem_addr=0x0000.
- rst asserted asynchronously mid-WAIT -> ifid_valid=0 and pc=RESET_PC immediately (before the next clk edge); fetch restarts from RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-state encoding and reset constants
package cpu_pkg;

  localparam logic [1:0] FETCH_REQ  = 2'd0;
  localparam logic [1:0] FETCH_WAIT = 2'd1;
  localparam logic [1:0] FETCH_HOLD = 2'd2;
  localparam logic [1:0] FETCH_DROP = 2'd3;

  localparam logic [15:0] NOP_INSTR        = 16'h0000;
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - IF/ID pipeline register with flush, load, hold and bubble
module ifid_reg
  import cpu_pkg::*;
#(
  parameter int N  = 16,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          load_i,
  input  logic          hold_i,
  input  logic [N-1:0]  instr_i,
  input  logic [AW-1:0] pc_i,
  output logic          valid_o,
  output logic [N-1:0]  instr_o,
  output logic [AW-1:0] pc_o
);

  logic          valid_q;
  logic [N-1:0]  instr_q;
  logic [AW-1:0] pc_q;

  // Flush beats load beats hold; with none of them the stage injects a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= N'(NOP_INSTR);
      pc_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      instr_q <= N'(NOP_INSTR);
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (!hold_i) begin
      valid_q <= 1'b0;
      instr_q <= N'(NOP_INSTR);
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, single-outstanding imem FSM, redirect
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int            N        = 16,
  parameter int            AW       = 16,
  parameter logic [AW-1:0] RESET_PC = AW'(DEFAULT_RESET_PC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_valid,
  input  logic [N-1:0]  imem_rdata,
  output logic          ifid_valid,
  output logic [N-1:0]  ifid_instr,
  output logic [AW-1:0] ifid_pc
);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [N-1:0]  hold_instr_q, hold_instr_d;
  logic [AW-1:0] hold_pc_q, hold_pc_d;
  logic          load;
  logic [N-1:0]  load_instr;
  logic [AW-1:0] load_pc;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    load         = 1'b0;
    load_instr   = imem_rdata;
    load_pc      = pc_q;
    if (branch_taken) begin
      // A redirect leaves at most one stale response in flight; DROP absorbs it.
      pc_d         = branch_target;
      hold_instr_d = '0;
      hold_pc_d    = '0;
      case (state_q)
        FETCH_REQ:  state_d = FETCH_DROP;
        FETCH_WAIT: state_d = imem_valid ? FETCH_REQ : FETCH_DROP;
        FETCH_HOLD: state_d = FETCH_REQ;
        default:    state_d = imem_valid ? FETCH_REQ : FETCH_DROP;
      endcase
    end else begin
      case (state_q)
        FETCH_REQ: state_d = FETCH_WAIT;
        FETCH_WAIT: begin
          if (imem_valid && !stall) begin
            load    = 1'b1;
            pc_d    = pc_q + AW'(1);
            state_d = FETCH_REQ;
          end else if (imem_valid) begin
            hold_instr_d = imem_rdata;
            hold_pc_d    = pc_q;
            state_d      = FETCH_HOLD;
          end
        end
        FETCH_HOLD: begin
          if (!stall) begin
            load       = 1'b1;
            load_instr = hold_instr_q;
            load_pc    = hold_pc_q;
            pc_d       = pc_q + AW'(1);
            state_d    = FETCH_REQ;
          end
        end
        default: begin
          if (imem_valid) state_d = FETCH_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH_REQ;
      pc_q         <= RESET_PC;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  assign imem_req  = (state_q == FETCH_REQ);
  assign imem_addr = pc_q;

  ifid_reg #(.N(N), .AW(AW)) u_ifid (
    .clk     (clk),
    .rst     (rst),
    .flush_i (branch_taken),
    .load_i  (load),
    .hold_i  (stall),
    .instr_i (load_instr),
    .pc_i    (load_pc),
    .valid_o (ifid_valid),
    .instr_o (ifid_instr),
    .pc_o    (ifid_pc)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid;
  logic [15:0] imem_rdata;
  logic        ifid_valid;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc;

  int n_cmp = 0;
  int n_err = 0;
  logic outstanding;

  fetch_stage #(.N(16), .AW(16), .RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_rdata    (imem_rdata),
    .ifid_valid    (ifid_valid),
    .ifid_instr    (ifid_instr),
    .ifid_pc       (ifid_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_ifid(input string tag, input logic v, input logic [15:0] ins, input logic [15:0] pc);
    check({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, v});
    check({tag, ".instr"}, {16'd0, ifid_instr}, {16'd0, ins});
    check({tag, ".pc"},    {16'd0, ifid_pc},    {16'd0, pc});
  endtask

  task automatic check_req(input string tag, input logic r, input logic [15:0] a);
    check({tag, ".req"},  {31'd0, imem_req},  {31'd0, r});
    check({tag, ".addr"}, {16'd0, imem_addr}, {16'd0, a});
  endtask

  // A response is legal only while a request is outstanding.
  always @(negedge clk) begin
    if (rst) begin
      outstanding = 1'b0;
    end else begin
      if (imem_valid) begin
        check("protocol.valid_without_req", {31'd0, outstanding}, 32'd1);
        outstanding = 1'b0;
      end
      if (imem_req) outstanding = 1'b1;
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
    imem_valid = 1'b0; imem_rdata = 16'h0000;
    #2;
    check_ifid("reset", 1'b0, 16'h0000, 16'h0000);
    check("reset.addr", {16'd0, imem_addr}, 32'h0000);

    // Basic 1-cycle memory fetch
    tick(); rst = 1'b0;
    check_req("t1.req0", 1'b1, 16'h0000);
    tick(); imem_valid = 1'b1; imem_rdata = 16'h1111;
    check("t1.wait.req", {31'd0, imem_req}, 32'd0);
    tick(); imem_valid = 1'b0;
    check_ifid("t1.ifid0", 1'b1, 16'h1111, 16'h0000);
    check_req("t1.req1", 1'b1, 16'h0001);
    tick(); imem_valid = 1'b1; imem_rdata = 16'h2222;
    check_ifid("t1.bubble", 1'b0, 16'h0000, 16'h0000);
    tick(); imem_valid = 1'b0; stall = 1'b1;
    check_ifid("t1.ifid1", 1'b1, 16'h2222, 16'h0001);
    check_req("t1.req2", 1'b1, 16'h0002);

    // Response during stall goes to the hold buffer
    tick(); imem_valid = 1'b1; imem_rdata = 16'hABCD;
    check_ifid("t2.held0", 1'b1, 16'h2222, 16'h0001);
    tick(); imem_valid = 1'b0;
    check_ifid("t2.held1", 1'b1, 16'h2222, 16'h0001);
    check("t2.hold.req1", {31'd0, imem_req}, 32'd0);
    tick();
    check("t2.hold.req2", {31'd0, imem_req}, 32'd0);
    tick(); stall = 1'b0;
    check_ifid("t2.held3", 1'b1, 16'h2222, 16'h0001);
    tick(); stall = 1'b1;
    check_ifid("t2.release", 1'b1, 16'hABCD, 16'h0002);
    check_req("t2.nextreq", 1'b1, 16'h0003);

    // Redirect in WAIT, stale response arrives two cycles later
    tick(); branch_taken = 1'b1; branch_target = 16'h0040;
    check_ifid("t3.before", 1'b1, 16'hABCD, 16'h0002);
    tick(); branch_taken = 1'b0; stall = 1'b0;
    check("t3.flush.valid", {31'd0, ifid_valid}, 32'd0);
    check("t3.flush.instr", {16'd0, ifid_instr}, 32'h0000);
    check_req("t3.drop", 1'b0, 16'h0040);
    tick(); imem_valid = 1'b1; imem_rdata = 16'hDEAD;
    check("t3.drop.req", {31'd0, imem_req}, 32'd0);
    tick(); imem_valid = 1'b0;
    check("t3.stale.valid", {31'd0, ifid_valid}, 32'd0);
    check("t3.stale.instr", {16'd0, ifid_instr}, 32'h0000);
    check_req("t3.target", 1'b1, 16'h0040);

    // Redirect with imem_valid and stall in the same cycle
    tick(); imem_valid = 1'b1; imem_rdata = 16'hBEEF; stall = 1'b1;
    branch_taken = 1'b1; branch_target = 16'h0100;
    tick(); imem_valid = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    check_req("t4.target", 1'b1, 16'h0100);
    check("t4.valid", {31'd0, ifid_valid}, 32'd0);
    tick(); imem_valid = 1'b1; imem_rdata = 16'h1234;
    tick(); imem_valid = 1'b0;
    check_ifid("t4.fetch", 1'b1, 16'h1234, 16'h0100);

    // Redirect to 0xFFFF from REQ, then wrap
    branch_taken = 1'b1; branch_target = 16'hFFFF;
    tick(); branch_taken = 1'b0;
    check_req("t5.drop", 1'b0, 16'hFFFF);
    check("t5.flush", {31'd0, ifid_valid}, 32'd0);
    imem_valid = 1'b1; imem_rdata = 16'h0BAD;
    tick(); imem_valid = 1'b0;
    check_req("t5.req", 1'b1, 16'hFFFF);
    check("t5.stale", {16'd0, ifid_instr}, 32'h0000);
    tick(); imem_valid = 1'b1; imem_rdata = 16'h7777;
    tick(); imem_valid = 1'b0; stall = 1'b1;
    check_ifid("t5.fetch", 1'b1, 16'h7777, 16'hFFFF);
    check_req("t5.wrap", 1'b1, 16'h0000);

    // Asynchronous reset mid-WAIT
    tick();
    check_ifid("t6.pre", 1'b1, 16'h7777, 16'hFFFF);
    #2 rst = 1'b1;
    #1;
    check_ifid("t6.async", 1'b0, 16'h0000, 16'h0000);
    check_req("t6.async", 1'b1, 16'h0000);
    stall = 1'b0;
    tick(); rst = 1'b0;
    check_req("t6.restart", 1'b1, 16'h0000);
    tick(); imem_valid = 1'b1; imem_rdata = 16'h5555;
    tick(); imem_valid = 1'b0;
    check_ifid("t6.fetch", 1'b1, 16'h5555, 16'h0000);
    check_req("t6.next", 1'b1, 16'h0001);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
